// File: rtl/bcd_arb_pkg.sv
// Purpose: shared types and defaults for the two-channel BCD converter arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_arb_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NDIG  = 5;

    // Converter sequencing: wait for a grant, shift WIDTH times, publish result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Channel index: 0 = score, 1 = timer.
    typedef logic ch_t;

endpackage

// File: rtl/bcd_add3.sv
// Purpose: one double-dabble digit correction, add 3 when the digit is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Purpose: two requesters share one iterative binary-to-BCD converter; optional
//          round-robin arbitration with macro BCD_ARB_RR_EN, fixed priority (ch0) otherwise.
// Latency: ack one cycle after grant edge k, done one cycle after edge k+WIDTH+1.
// Backpressure: req is only sampled in IDLE; requesters hold req/val until ack.
module bcd_conv_arbiter
    import bcd_arb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NDIG  = DEF_NDIG
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          req,
    input  logic [WIDTH-1:0]    val0,
    input  logic [WIDTH-1:0]    val1,
    output logic [1:0]          ack,
    output logic                busy,
    output logic [1:0]          done,
    output logic [4*NDIG-1:0]   bcd0,
    output logic [4*NDIG-1:0]   bcd1
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * NDIG;

    state_t           state;
    state_t           state_nxt;
    logic             take;
    logic             grant;
    ch_t              grant_ch;
    ch_t              cur_ch;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] bin;
    logic [BW-1:0]    digits;
    logic [BW-1:0]    digits_adj;

`ifdef BCD_ARB_RR_EN
    // Channel that wins the next simultaneous request.
    ch_t              rr_ptr;
`endif

    // Per-digit correction applied ahead of every shift.
    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (digits[4*g +: 4]),
            .dout (digits_adj[4*g +: 4])
        );
    end

    // Arbitration: pick one requester; only consumed when the converter is idle.
    always_comb begin
        grant    = |req;
        grant_ch = 1'b0;
`ifdef BCD_ARB_RR_EN
        if (req == 2'b11)
            grant_ch = rr_ptr;
        else
            grant_ch = req[1] & ~req[0];
`else
        grant_ch = ~req[0];
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; the counter reaching WIDTH-1 marks the final shift.
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = SHIFT;
                    take      = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH - 1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on grant, shift-add-3 per SHIFT cycle, publish in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            bin    <= '0;
            digits <= '0;
            cur_ch <= 1'b0;
            ack    <= '0;
            done   <= '0;
            bcd0   <= '0;
            bcd1   <= '0;
`ifdef BCD_ARB_RR_EN
            rr_ptr <= 1'b0;
`endif
        end else begin
            ack  <= '0;
            done <= '0;
            case (state)
                IDLE: begin
                    if (take) begin
                        bin           <= grant_ch ? val1 : val0;
                        digits        <= '0;
                        cnt           <= '0;
                        cur_ch        <= grant_ch;
                        ack[grant_ch] <= 1'b1;
`ifdef BCD_ARB_RR_EN
                        rr_ptr        <= ~grant_ch;
`endif
                    end
                end
                SHIFT: begin
                    digits <= BW'({digits_adj, bin[WIDTH-1]});
                    bin    <= {bin[WIDTH-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                end
                DONE: begin
                    if (cur_ch)
                        bcd1 <= digits;
                    else
                        bcd0 <= digits;
                    done[cur_ch] <= 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 16, binary input width per requester.
REQ-002 SHALL have parameter NDIG, default 5, number of BCD output digits; 10^NDIG > 2^WIDTH-1 is required.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-channel conversion request (0 = score, 1 = timer).
REQ-006 SHALL have port val0  input  WIDTH  channel 0 binary value.
REQ-007 SHALL have port val1  input  WIDTH  channel 1 binary value.
REQ-008 SHALL have port ack  output  2  one-cycle pulse: request accepted, value captured.
REQ-009 SHALL have port busy  output  1  high while the converter is not IDLE.
REQ-010 SHALL have port done  output  2  one-cycle pulse: channel result updated.
REQ-011 SHALL have port bcd0  output  4*NDIG  channel 0 packed BCD result, LS digit in [3:0].
REQ-012 SHALL have port bcd1  output  4*NDIG  channel 1 packed BCD result.

Function
REQ-013 SHALL share one iterative shift-add-3 (double-dabble) converter between both channels.
REQ-014 SHALL use FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on grant, SHIFT->DONE after WIDTH shifts, DONE->IDLE unconditionally.
REQ-015 SHALL, in IDLE at edge k with any req bit high, capture the granted channel's value and channel index, and drive ack[ch]=1 for the cycle after edge k only.
REQ-016 SHALL, per SHIFT edge, add 3 to every BCD digit >=5, then shift left one bit, taking the binary MSB into digit-0 LSB.
REQ-017 SHALL perform exactly WIDTH shifts on edges k+1..k+WIDTH.
REQ-018 SHALL, at edge k+WIDTH+1 (DONE), write the result to bcd<ch>, pulse done[ch] for one cycle, and return to IDLE; the other channel's register is unchanged.
REQ-019 SHALL accept the next request no earlier than edge k+WIDTH+2; req is ignored outside IDLE.
REQ-020 SHALL ignore val changes after the capture edge; a requester holds req and val until ack; req dropped before grant is never served.
REQ-021 SHALL hold bcd0/bcd1 stable between done pulses; they are valid continuously after first done.
REQ-022 SHALL never assert ack or done on more than one bit simultaneously.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force state IDLE, ack=0, done=0, busy=0, bcd0=0, bcd1=0, shift counter=0, round-robin pointer=channel 0 next.
REQ-024 SHALL abort any in-flight conversion on reset with no done pulse, and resume normal operation on the first edge after rst_n rises.

Configuration
REQ-025 SHALL, with macro BCD_ARB_RR_EN defined, arbitrate round-robin: on simultaneous req, grant the channel not granted last; the pointer updates only on grant.
REQ-026 SHALL, without BCD_ARB_RR_EN, use fixed priority: channel 0 wins every simultaneous request.

Structure
REQ-027 SHALL place the FSM state enum, channel-index typedef and default WIDTH/NDIG constants in shared package bcd_arb_pkg.
REQ-028 SHALL instantiate NDIG copies of one combinational sub-module bcd_add3 (4-bit in, 4-bit out: x>=5 ? x+3 : x).
REQ-029 SHALL size the shift counter to ceil(log2(WIDTH+1)) bits with no wrap within a conversion.

Verification
REQ-030 SHALL cover: req=01, val0=12345 at edge k -> ack=01 after k, done=01 after k+17, bcd0=0x12345, bcd1 unchanged.
REQ-031 SHALL cover: val1=65535, then val1=0 -> bcd1=0x65535, then 0x00000; done[1] pulses once per conversion.
REQ-032 SHALL cover: req=11 held, RR build -> grants alternate ch0, ch1, ch0; fixed build -> ch0 granted repeatedly, ch1 never acked.
REQ-033 SHALL cover: rst_n low at edge k+8 of a conversion -> busy=0, bcd0=bcd1=0, no done; a new req after release converts correctly.
REQ-034 SHALL cover: req=10 during SHIFT -> no ack until IDLE; val1 changed after ack -> result reflects the captured value.
